bias_fetch_sched: RTL and testbench

Sequencer and arbiter for the single-port 2k-word bias SRAM. It streams bias words for a programmed run of output channels to the EPU PE array over a valid/ready FIFO interface. It also shares the SRAM port with the AXI-side bias loader: writes have priority and reads stall. It sits between the EPU wrapper (loader side), the bias SRAM and the EPU datapath.

---
 rtl/bias_fetch_sched_if.sv | 45 ++++
 rtl/bias_fetch_sched.sv | 139 +++++++++++++
 tb/tb_bias_fetch_sched.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bias_fetch_sched_if.sv
// Handshake/bus bundle for bias_fetch_sched: run control, loader write port,
// single-port bias SRAM port and the bias output stream.
interface bias_fetch_sched_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
);
  logic              start_i;
  logic [ADDR_W-1:0] base_addr_i;
  logic [ADDR_W:0]   num_ch_i;
  logic              busy_o;
  logic              done_o;

  logic              wr_req_i;
  logic [ADDR_W-1:0] wr_addr_i;
  logic [DATA_W-1:0] wr_data_i;
  logic              wr_gnt_o;

  logic              sram_cs_o;
  logic              sram_oe_o;
  logic              sram_we_o;
  logic [ADDR_W-1:0] sram_addr_o;
  logic [DATA_W-1:0] sram_wdata_o;
  logic [DATA_W-1:0] sram_rdata_i;

  logic              bias_valid_o;
  logic [DATA_W-1:0] bias_data_o;
  logic              bias_last_o;
  logic              bias_ready_i;

  // Scheduler side
  modport slave (
    input  start_i, base_addr_i, num_ch_i, wr_req_i, wr_addr_i, wr_data_i,
           sram_rdata_i, bias_ready_i,
    output busy_o, done_o, wr_gnt_o, sram_cs_o, sram_oe_o, sram_we_o,
           sram_addr_o, sram_wdata_o, bias_valid_o, bias_data_o, bias_last_o
  );

  // Environment side: controller, loader, SRAM and EPU consumer
  modport master (
    output start_i, base_addr_i, num_ch_i, wr_req_i, wr_addr_i, wr_data_i,
           sram_rdata_i, bias_ready_i,
    input  busy_o, done_o, wr_gnt_o, sram_cs_o, sram_oe_o, sram_we_o,
           sram_addr_o, sram_wdata_o, bias_valid_o, bias_data_o, bias_last_o
  );
endinterface

// File: rtl/bias_fetch_sched.sv
// Bias SRAM fetch sequencer/arbiter: streams a run of bias words through a small FIFO;
// loader writes win the SRAM port. Optional BIAS_SAT16_EN saturates output words to int16.
module bias_fetch_sched #(
  parameter int ADDR_W     = 11,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  bias_fetch_sched_if.slave bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [PTR_W+1:0] DEPTH_V = (PTR_W + 2)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q;
  logic [CNT_W-1:0]  num_q, issued_q, popped_q;
  logic              inflight_q;

  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]    count_q, count_d;

  logic              rd_issue, push, pop, fifo_empty, start_acc;
  logic [PTR_W+1:0]  occupancy;
  logic [DATA_W-1:0] head;

  // An outstanding read already owns a FIFO slot, so it counts toward occupancy
  assign occupancy  = {1'b0, count_q} + {{(PTR_W+1){1'b0}}, inflight_q};
  assign rd_issue   = (state_q == S_FETCH) && !bus.wr_req_i &&
                      (issued_q < num_q) && (occupancy < DEPTH_V);
  assign push       = inflight_q;
  assign fifo_empty = (count_q == '0);
  assign pop        = !fifo_empty && bus.bias_ready_i;
  assign start_acc  = (state_q == S_IDLE) && bus.start_i;
  assign head       = fifo_mem[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start_i) state_d = (bus.num_ch_i == '0) ? S_DONE : S_FETCH;
      S_FETCH: if (issued_q == num_q) state_d = S_DRAIN;
      // Leave as the final word is popped so done lands one cycle after that handshake
      S_DRAIN: if (!inflight_q && (count_d == '0)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q     <= '0;
      num_q      <= '0;
      issued_q   <= '0;
      popped_q   <= '0;
      inflight_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      inflight_q <= rd_issue;
      count_q    <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (start_acc) begin
        base_q   <= bus.base_addr_i;
        num_q    <= bus.num_ch_i;
        issued_q <= '0;
        popped_q <= '0;
      end else begin
        if (rd_issue) issued_q <= issued_q + 1'b1;
        if (pop)      popped_q <= popped_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= bus.sram_rdata_i;
  end

  // SRAM port mux; forced quiet while reset is held
  always_comb begin
    bus.sram_cs_o    = 1'b0;
    bus.sram_oe_o    = 1'b0;
    bus.sram_we_o    = 1'b0;
    bus.sram_addr_o  = '0;
    bus.sram_wdata_o = '0;
    bus.wr_gnt_o     = 1'b0;
    if (!rst && bus.wr_req_i) begin
      bus.sram_cs_o    = 1'b1;
      bus.sram_we_o    = 1'b1;
      bus.sram_addr_o  = bus.wr_addr_i;
      bus.sram_wdata_o = bus.wr_data_i;
      bus.wr_gnt_o     = 1'b1;
    end else if (!rst && rd_issue) begin
      bus.sram_cs_o   = 1'b1;
      bus.sram_oe_o   = 1'b1;
      bus.sram_addr_o = base_q + issued_q[ADDR_W-1:0];
    end
  end

  assign bus.busy_o       = (state_q != S_IDLE);
  assign bus.done_o       = (state_q == S_DONE);
  assign bus.bias_valid_o = !fifo_empty;
  assign bus.bias_last_o  = !fifo_empty && (popped_q == num_q - CNT_W'(1));

`ifdef BIAS_SAT16_EN
  localparam logic signed [DATA_W-1:0] SAT_MAX = {{(DATA_W-15){1'b0}}, {15{1'b1}}};
  localparam logic signed [DATA_W-1:0] SAT_MIN = {{(DATA_W-15){1'b1}}, {15{1'b0}}};
  logic [DATA_W-1:0] head_sat;
  always_comb begin
    head_sat = head;
    if ($signed(head) > SAT_MAX)      head_sat = SAT_MAX;
    else if ($signed(head) < SAT_MIN) head_sat = SAT_MIN;
  end
  assign bus.bias_data_o = fifo_empty ? '0 : head_sat;
`else
  assign bus.bias_data_o = fifo_empty ? '0 : head;
`endif

endmodule

// File: tb/tb_bias_fetch_sched.sv
// Bench for bias_fetch_sched: SRAM model, stream-level reference model checked every
// cycle, plus directed runs with literal expectations.
module tb_bias_fetch_sched;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bias_fetch_sched_if #(.ADDR_W(11), .DATA_W(32)) bus ();

  bias_fetch_sched #(.ADDR_W(11), .DATA_W(32), .FIFO_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] sram    [2048];
  logic [31:0] ref_mem [2048];

  // Bench SRAM: one-cycle read latency
  always @(posedge clk) begin
    if (bus.sram_cs_o && bus.sram_we_o) sram[bus.sram_addr_o] <= bus.sram_wdata_o;
    if (bus.sram_cs_o && bus.sram_oe_o) bus.sram_rdata_i <= sram[bus.sram_addr_o];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_word(input logic [31:0] w);
`ifdef BIAS_SAT16_EN
    if ($signed(w) > 32767)  return 32'h0000_7FFF;
    if ($signed(w) < -32768) return 32'hFFFF_8000;
`endif
    return w;
  endfunction

  // Reference model state
  logic [31:0] exp_q[$];
  logic [31:0] rx_words[$];
  logic        model_busy = 1'b0;
  logic        done_due = 1'b0;
  logic [10:0] exp_rd_addr = '0;
  int          rd_left = 0;
  int          rd_total = 0;
  int          gnt_total = 0;
  int          valid_total = 0;

  always @(negedge clk) begin
    logic next_done;
    next_done = 1'b0;
    if (rst) begin
      chk("rst_busy",  32'(bus.busy_o), 0);
      chk("rst_done",  32'(bus.done_o), 0);
      chk("rst_valid", 32'(bus.bias_valid_o), 0);
      chk("rst_data",  bus.bias_data_o, 0);
      chk("rst_cs",    32'(bus.sram_cs_o), 0);
      chk("rst_gnt",   32'(bus.wr_gnt_o), 0);
      exp_q.delete();
      model_busy = 1'b0;
      done_due   = 1'b0;
      rd_left    = 0;
    end else begin
      chk("busy", 32'(bus.busy_o), 32'(model_busy));
      chk("done", 32'(bus.done_o), 32'(done_due));
      if (bus.bias_valid_o) begin
        valid_total++;
        if (exp_q.size() == 0) begin
          chk("unexpected_word", 32'(bus.bias_valid_o), 0);
        end else begin
          chk("data", bus.bias_data_o, exp_q[0]);
          chk("last", 32'(bus.bias_last_o), 32'(exp_q.size() == 1));
          if (bus.bias_ready_i) begin
            rx_words.push_back(bus.bias_data_o);
            void'(exp_q.pop_front());
            if (exp_q.size() == 0) next_done = 1'b1;
          end
        end
      end
      if (bus.wr_req_i) begin
        gnt_total++;
        chk("wr_gnt",   32'(bus.wr_gnt_o), 1);
        chk("wr_we",    32'({bus.sram_cs_o, bus.sram_we_o, bus.sram_oe_o}), 32'b110);
        chk("wr_addr",  32'(bus.sram_addr_o), 32'(bus.wr_addr_i));
        chk("wr_wdata", bus.sram_wdata_o, bus.wr_data_i);
      end else begin
        chk("no_gnt", 32'(bus.wr_gnt_o), 0);
      end
      if (bus.sram_cs_o && bus.sram_oe_o) begin
        chk("read_wanted", 32'(rd_left > 0), 1);
        chk("rd_addr", 32'(bus.sram_addr_o), 32'(exp_rd_addr));
        exp_rd_addr = exp_rd_addr + 11'd1;
        rd_left--;
        rd_total++;
      end
      if (!bus.sram_cs_o)
        chk("idle_port", 32'({bus.sram_oe_o, bus.sram_we_o}) | 32'(bus.sram_addr_o) |
            bus.sram_wdata_o, 0);
      if (done_due) model_busy = 1'b0;
      else if (bus.start_i && !model_busy) begin
        model_busy  = 1'b1;
        exp_rd_addr = bus.base_addr_i;
        rd_left     = int'(bus.num_ch_i);
        for (int i = 0; i < int'(bus.num_ch_i); i++)
          exp_q.push_back(model_word(ref_mem[bus.base_addr_i + 11'(i)]));
        if (bus.num_ch_i == '0) next_done = 1'b1;
      end
      done_due = next_done;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_word(input logic [10:0] a, input logic [31:0] d);
    bus.wr_req_i  = 1'b1;
    bus.wr_addr_i = a;
    bus.wr_data_i = d;
    ref_mem[a]    = d;
    tick();
    bus.wr_req_i  = 1'b0;
  endtask

  task automatic start_run(input logic [10:0] base, input logic [11:0] num);
    bus.start_i     = 1'b1;
    bus.base_addr_i = base;
    bus.num_ch_i    = num;
    tick();
    bus.start_i     = 1'b0;
  endtask

  task automatic wait_done(input string name);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (bus.done_o) seen = 1'b1;
    end
    chk(name, 32'(seen), 1);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, rd_base, rx_base, g_base, v_base;
    for (int i = 0; i < 2048; i++) begin
      sram[i]    = '0;
      ref_mem[i] = '0;
    end
    bus.start_i = 0; bus.base_addr_i = '0; bus.num_ch_i = '0;
    bus.wr_req_i = 0; bus.wr_addr_i = '0; bus.wr_data_i = '0;
    bus.bias_ready_i = 1'b1; bus.sram_rdata_i = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) wr_word(11'(i), 32'(i + 1));

    // Basic run, latency, ignored second start
    rx_base = rx_words.size();
    start_run(11'd0, 12'd8);
    @(negedge clk);
    chk("busy_after_start", 32'(bus.busy_o), 1);
    lat = 0;
    while (!bus.bias_valid_o && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("first_word_latency", 32'(lat), 2);
    tick();
    start_run(11'd500, 12'd3);
    wait_done("done_basic");
    chk("basic_count", 32'(rx_words.size() - rx_base), 8);
    chk("basic_first", rx_words[rx_base], 32'd1);
    chk("basic_last",  rx_words[rx_base + 7], 32'd8);
    @(negedge clk);
    chk("busy_low_after", 32'(bus.busy_o), 0);
    tick();

    // Back-pressure: FIFO plus in-flight cap at four reads
    bus.bias_ready_i = 1'b0;
    rd_base = rd_total;
    rx_base = rx_words.size();
    start_run(11'd0, 12'd8);
    repeat (10) tick();
    chk("stall_reads", 32'(rd_total - rd_base), 4);
    bus.bias_ready_i = 1'b1;
    wait_done("done_stall");
    chk("stall_count", 32'(rx_words.size() - rx_base), 8);
    chk("stall_word3", rx_words[rx_base + 3], 32'd4);

    // Address wrap past 2047
    wr_word(11'd2046, 32'h0000_00A1);
    wr_word(11'd2047, 32'h0000_00B2);
    wr_word(11'd0,    32'h0000_00C3);
    wr_word(11'd1,    32'h0000_00D4);
    rx_base = rx_words.size();
    start_run(11'd2046, 12'd4);
    wait_done("done_wrap");
    chk("wrap_0", rx_words[rx_base],     32'h0000_00A1);
    chk("wrap_1", rx_words[rx_base + 1], 32'h0000_00B2);
    chk("wrap_2", rx_words[rx_base + 2], 32'h0000_00C3);
    chk("wrap_3", rx_words[rx_base + 3], 32'h0000_00D4);

    // Loader writes interleaved with a fetch
    g_base = gnt_total;
    rx_base = rx_words.size();
    start_run(11'd0, 12'd8);
    tick();
    bus.wr_req_i = 1'b1; bus.wr_addr_i = 11'd100; bus.wr_data_i = 32'h0000_1234;
    ref_mem[100] = 32'h0000_1234;
    repeat (3) tick();
    bus.wr_req_i = 1'b0;
    wait_done("done_wrmix");
    chk("wrmix_grants", 32'(gnt_total - g_base), 3);
    chk("wrmix_count", 32'(rx_words.size() - rx_base), 8);
    start_run(11'd100, 12'd1);
    wait_done("done_rdback");
    chk("rdback_100", rx_words[rx_words.size() - 1], 32'h0000_1234);

    // Zero-length run
    v_base = valid_total;
    start_run(11'd5, 12'd0);
    @(negedge clk);
    chk("num0_done", 32'(bus.done_o), 1);
    tick();
    tick();
    chk("num0_no_valid", 32'(valid_total - v_base), 0);

    // Reset in the middle of DRAIN
    bus.bias_ready_i = 1'b0;
    start_run(11'd0, 12'd4);
    repeat (8) tick();
    @(posedge clk);
    #2;
    rst = 1'b1;
    bus.wr_req_i = 1'b1; bus.wr_addr_i = 11'd9; bus.wr_data_i = 32'hDEAD_BEEF;
    #1;
    chk("rst_now_outputs", 32'({bus.busy_o, bus.done_o, bus.bias_valid_o, bus.bias_last_o,
        bus.sram_cs_o, bus.sram_oe_o, bus.sram_we_o, bus.wr_gnt_o}), 0);
    chk("rst_now_bus", 32'(bus.sram_addr_o) | bus.sram_wdata_o | bus.bias_data_o, 0);
    @(negedge clk);
    tick();
    rst = 1'b0;
    bus.wr_req_i = 1'b0;
    bus.bias_ready_i = 1'b1;
    repeat (4) tick();
    rx_base = rx_words.size();
    start_run(11'd2, 12'd3);
    wait_done("done_after_rst");
    chk("after_rst_count", 32'(rx_words.size() - rx_base), 3);
    chk("after_rst_word0", rx_words[rx_base], 32'd3);

    // Saturation boundary
    wr_word(11'd200, 32'h0001_2345);
    wr_word(11'd201, 32'hFFFF_0000);
    wr_word(11'd202, 32'h0000_7FFF);
    rx_base = rx_words.size();
    start_run(11'd200, 12'd3);
    wait_done("done_sat");
`ifdef BIAS_SAT16_EN
    chk("sat_pos", rx_words[rx_base],     32'h0000_7FFF);
    chk("sat_neg", rx_words[rx_base + 1], 32'hFFFF_8000);
`else
    chk("raw_pos", rx_words[rx_base],     32'h0001_2345);
    chk("raw_neg", rx_words[rx_base + 1], 32'hFFFF_0000);
`endif
    chk("sat_edge", rx_words[rx_base + 2], 32'h0000_7FFF);

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
